// File: rtl/nibble_add_seq.sv
// Multi-nibble binary/BCD add sequencer: one shared 4-bit ripple adder,
// one nibble per cycle, plus a +6 correction pass per decimal nibble that needs it.

module nibble_add4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [4:0] c;

    always_comb begin
        c[0] = ci;
        for (int i = 0; i < 4; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        co = c[4];
    end
endmodule

// state | meaning
// IDLE  | waiting for start; operands latched on accept
// ADD   | add opa/opb nibble idx with running carry
// ADJ   | decimal +6 correction of raw nibble rn
// DONE  | one-cycle done pulse, result valid
module nibble_add_seq #(
    parameter int NIBBLES = 4,
    parameter int W       = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         dec,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         busy,
    output logic         done
);
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        ADJ  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    logic [W-1:0]  opa;
    logic [W-1:0]  opb;
    logic          carry;
    logic          dec_r;
    logic [IW-1:0] idx;
    logic [3:0]    rn;

    logic [3:0]    add_x;
    logic [3:0]    add_y;
    logic          add_ci;
    logic [3:0]    add_s;
    logic          add_co;
    logic          need_adj;
    logic          last;

    nibble_add4 u_add (
        .x  (add_x),
        .y  (add_y),
        .ci (add_ci),
        .s  (add_s),
        .co (add_co)
    );

    always_comb begin
        add_x  = opa[{idx, 2'b00} +: 4];
        add_y  = opb[{idx, 2'b00} +: 4];
        add_ci = carry;
        if (state == ADJ) begin
            add_x  = rn;
            add_y  = 4'h6;
            add_ci = 1'b0;
        end
    end

    // A carry out of the nibble also needs correction (e.g. 9+9 = 0x12).
    assign need_adj = dec_r && ((add_s > 4'd9) || add_co);
    assign last     = (idx == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            dec_r <= 1'b0;
            idx   <= '0;
            rn    <= 4'h0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= b;
                        carry <= cin;
                        dec_r <= dec;
                        idx   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                        busy  <= 1'b1;
                        state <= ADD;
                    end
                end
                ADD: begin
                    if (need_adj) begin
                        rn    <= add_s;
                        state <= ADJ;
                    end else begin
                        sum[{idx, 2'b00} +: 4] <= add_s;
                        carry <= add_co;
                        if (last) begin
                            cout  <= add_co;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ADJ: begin
                    sum[{idx, 2'b00} +: 4] <= add_s;
                    carry <= 1'b1;
                    if (last) begin
                        cout  <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= ADD;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/nibble_add_seq.md
# nibble_add_seq

Multi-nibble add sequencer for the m6502 model. It performs a 4×NIBBLES-bit binary or BCD addition by time-multiplexing a single internal 4-bit ripple-carry adder, one nibble per cycle. In decimal mode it reuses the same adder for a +6 correction pass on each nibble that needs it. It sits beside the ALU and serves multi-byte and decimal-mode add operations through a start/done handshake.

## Interface
- NIBBLES, 4, number of 4-bit digits per operand (operand width W = 4*NIBBLES); legal range 1..8
- clk  input  1  rising-edge clock; only clock in the block
- rst_n  input  1  synchronous reset, active-low, sampled on rising clk
- start  input  1  request; accepted only in IDLE
- dec  input  1  1 = BCD add, 0 = binary add; latched at start
- a  input  W  operand A; latched at start
- b  input  W  operand B; latched at start
- cin  input  1  carry in; latched at start
- sum  output  W  result register; held until next accepted start
- cout  output  1  final carry out; held with sum
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse when sum/cout become valid

## Operation
- One internal 4-bit adder instance: inputs x[3:0], y[3:0], ci; outputs s[3:0], co. The FSM muxes its inputs.
- Registers:
  - opa, opb, carry, dec_r
  - nibble index idx (clog2(NIBBLES) bits, minimum 1)
  - raw nibble rn
  - sum, cout
- States: IDLE, ADD, ADJ, DONE.
- IDLE:
  - busy=0.
  - On start=1, latch a, b, cin, dec.
  - Set idx=0, clear sum and cout, go to ADD.
- ADD (adder inputs x=opa[idx], y=opb[idx], ci=carry):
  - Binary, or decimal with s<=9 and co=0:
    - Write s into sum[idx] and set carry=co.
    - If idx=NIBBLES-1, set cout=co and go to DONE.
    - Otherwise increment idx and stay in ADD.
  - Decimal with s>9 or co=1: store rn=s and go to ADJ.
- ADJ (adder inputs x=rn, y=4'h6, ci=0):
  - Write s into sum[idx]; set carry=1.
  - If last nibble, set cout=1 and go to DONE.
  - Otherwise increment idx and go back to ADD.
  - The co of the ADJ pass is ignored.
- DONE: done=1 for one cycle, busy=0, then go to IDLE.
- Decimal mode with an input nibble >9 is not a legal BCD input. The block still follows the rules above mechanically and does not flag an error.
- start while busy or in DONE is ignored (not queued).
- Operand inputs a/b/cin/dec may change freely after the start cycle.

## Timing
- Reset (rst_n=0 at a rising edge) forces the following:
  - state=IDLE
  - sum=0, cout=0, busy=0, done=0
  - idx=0, carry=0, rn=0
- Reset mid-operation aborts the operation; no done pulse is produced.
- Cycle numbering: start is sampled high at the end of cycle 0.
  - Cycles 1..K are busy (ADD/ADJ).
  - done is high in cycle K+1, with sum/cout valid in that cycle.
- K = NIBBLES + (number of ADJ passes):
  - Binary: K = NIBBLES, so done in cycle NIBBLES+1.
  - Decimal worst case: K = 2*NIBBLES.
- busy is high exactly in cycles 1..K.
- A new start is accepted in cycle K+2 at the earliest (the first IDLE cycle after DONE).
- sum bits are updated nibble-by-nibble while busy. They are valid only when done is high and afterwards.
- The adder path is combinational within one cycle; no multicycle paths.

## Test plan
- Binary: a=16'h1234, b=16'h0FFF, cin=0, dec=0 → sum=16'h2233, cout=0; done in cycle 5; busy in cycles 1–4.
- Binary overflow: a=16'hFFFF, b=16'h0001, cin=0 → sum=16'h0000, cout=1; done in cycle 5.
- Decimal ripple: a=16'h0999, b=16'h0001, dec=1 → sum=16'h1000, cout=0; 3 ADJ passes, done in cycle 8. Decimal carry-in: a=16'h0045, b=16'h0054, cin=1 → sum=16'h0100, done in cycle 7.
- Decimal full carry with co-triggered adjust: a=16'h9999, b=16'h0001 → sum=16'h0000, cout=1, done in cycle 9. a=16'h0009, b=16'h0009 → sum=16'h0018, done in cycle 6.
- Handshake: start held high through busy plus new operands in cycle 2 → ignored, result matches the first operands. A second start in the first IDLE cycle after DONE is accepted.
- Reset mid-op: rst_n=0 in cycle 2 of a decimal add → in the next cycle state=IDLE, sum=0, cout=0, busy=0, and no done pulse. A following start completes normally.
